// File: rtl/stoplight_ctrl.sv
// stoplight_ctrl: round-robin N_DIR traffic lights with request-shortened green; walk lamps with STOPLIGHT_WALK_EN
module stoplight_ctrl #(
   parameter int N_DIR = 4,
   parameter int CNT_W = 8,
   parameter int GREEN_CYC = 8,
   parameter int MIN_GREEN_CYC = 3,
   parameter int YELLOW_CYC = 2,
   parameter int ALLRED_CYC = 1
`ifdef STOPLIGHT_WALK_EN
   , parameter int WALK_CYC = 4
`endif
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic [N_DIR-1:0]         req,
   output logic [N_DIR-1:0]         red,
   output logic [N_DIR-1:0]         yellow,
   output logic [N_DIR-1:0]         green,
   output logic [$clog2(N_DIR)-1:0] active_dir,
   output logic [N_DIR-1:0]         pending
`ifdef STOPLIGHT_WALK_EN
   , output logic [N_DIR-1:0]       walk
`endif
);
   localparam int DW = $clog2(N_DIR);
`ifdef STOPLIGHT_WALK_EN
   localparam int MIN_EFF = MIN_GREEN_CYC > WALK_CYC ? MIN_GREEN_CYC : WALK_CYC;
`else
   localparam int MIN_EFF = MIN_GREEN_CYC;
`endif
   typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} state_t;
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [DW-1:0] next_dir, next_dir_nxt, idx;
   logic [N_DIR-1:0] act_oh, nd_oh, others, pend_nxt;
   logic enter_green;
   // next state, next-direction search and request latching
   always_comb begin
      act_oh = '0;
      act_oh[active_dir] = 1'b1;
      nd_oh = '0;
      nd_oh[next_dir] = 1'b1;
      others = pending & ~act_oh;
      state_nxt = state;
      case (state)
         ALLRED:  if (cnt == CNT_W'(ALLRED_CYC - 1)) state_nxt = GREEN;
         GREEN:   if (cnt == CNT_W'(GREEN_CYC - 1) || (cnt >= CNT_W'(MIN_EFF - 1) && |others)) state_nxt = YELLOW;
         YELLOW:  if (cnt == CNT_W'(YELLOW_CYC - 1)) state_nxt = ALLRED;
         default: state_nxt = ALLRED;
      endcase
      next_dir_nxt = DW'((int'(active_dir) + 1) % N_DIR);
      idx = '0;
      for (int k = N_DIR - 1; k >= 1; k--) begin
         idx = DW'((int'(active_dir) + k) % N_DIR);
         if (others[idx]) next_dir_nxt = idx;
      end
      enter_green = state == ALLRED && state_nxt == GREEN;
      pend_nxt = (pending | (req & ~(state == GREEN ? act_oh : '0))) & ~(enter_green ? nd_oh : '0);
   end
   // state, phase timer, direction and pending registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= ALLRED;
         cnt <= '0;
         active_dir <= '0;
         next_dir <= '0;
         pending <= '0;
      end else begin
         state <= state_nxt;
         cnt <= state_nxt != state ? '0 : cnt + 1'b1;
         if (state == YELLOW && state_nxt == ALLRED) next_dir <= next_dir_nxt;
         if (enter_green) active_dir <= next_dir;
         pending <= pend_nxt;
      end
   end
   // lamps decoded straight from registers
   always_comb begin
      red = state == ALLRED ? '1 : ~act_oh;
      yellow = state == YELLOW ? act_oh : '0;
      green = state == GREEN ? act_oh : '0;
`ifdef STOPLIGHT_WALK_EN
      walk = (state == GREEN && {1'b0, cnt} < (CNT_W + 1)'(WALK_CYC)) ? act_oh : '0;
`endif
   end
endmodule

// File: tb/tb_stoplight_ctrl.sv
// tb_stoplight_ctrl: scoreboard bench for stoplight_ctrl with directed phase sequences
module tb_stoplight_ctrl;
`ifdef STOPLIGHT_WALK_EN
   localparam int MIN_G = 4;
   localparam bit WALK = 1'b1;
`else
   localparam int MIN_G = 3;
   localparam bit WALK = 1'b0;
`endif
   logic clk = 1'b0, nrst = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] red, yellow, green, pending, walk_v;
   logic [1:0] active_dir;
   typedef struct packed {logic [3:0] r, y, g, p, w; logic [1:0] a;} exp_t;
   exp_t q[$];
   int total = 0, bad = 0;

   stoplight_ctrl dut (
      .clk(clk), .nrst(nrst), .req(req), .red(red), .yellow(yellow), .green(green),
      .active_dir(active_dir), .pending(pending)
`ifdef STOPLIGHT_WALK_EN
      , .walk(walk_v)
`endif
   );
`ifndef STOPLIGHT_WALK_EN
   assign walk_v = '0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
      end
   endtask

   // k: 0 allred, 1 green, 2 yellow; d: owning direction; c: cnt within green
   task automatic cyc(input int k, input int d, input logic [3:0] p, input int c);
      exp_t e;
      logic [3:0] oh;
      oh = 4'b0001 << d;
      e.r = k == 0 ? 4'hf : ~oh;
      e.y = k == 2 ? oh : 4'h0;
      e.g = k == 1 ? oh : 4'h0;
      e.w = (WALK && k == 1 && c < 4) ? oh : 4'h0;
      e.p = p;
      e.a = 2'(d);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic phase(input int k, input int d, input int n, input logic [3:0] p);
      for (int i = 0; i < n; i++) cyc(k, d, p, i);
   endtask

   // monitor: compare the current cycle against the scoreboard and check invariants
   always @(negedge clk) begin
      exp_t e;
      logic ok;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("red", red, e.r);
         check("yellow", yellow, e.y);
         check("green", green, e.g);
         check("active_dir", active_dir, e.a);
         check("pending", pending, e.p);
         check("walk", walk_v, e.w);
         ok = 1'b1;
         for (int i = 0; i < 4; i++) if (int'(red[i]) + int'(yellow[i]) + int'(green[i]) != 1) ok = 1'b0;
         check("one_lamp_per_dir", ok, 1);
         check("one_dir_non_red", $countones(~red) <= 1, 1);
      end
   end

   initial begin
      @(posedge clk);
      #1;
      check("por_red", red, 4'hf);
      check("por_green", green, 0);
      nrst = 1'b1;
      cyc(0, 0, 4'h0, 0);
      for (int d = 0; d < 4; d++) begin
         phase(1, d, 8, 4'h0);
         phase(2, d, 2, 4'h0);
         phase(0, d, 1, 4'h0);
      end
      cyc(1, 0, 4'h0, 0);
      req = 4'b0100;
      cyc(1, 0, 4'h0, 1);
      req = 4'h0;
      for (int c = 2; c < MIN_G; c++) cyc(1, 0, 4'b0100, c);
      phase(2, 0, 2, 4'b0100);
      phase(0, 0, 1, 4'b0100);
      phase(1, 2, 8, 4'h0);
      phase(2, 2, 2, 4'h0);
      phase(0, 2, 1, 4'h0);
      phase(1, 3, 8, 4'h0);
      phase(2, 3, 2, 4'h0);
      phase(0, 3, 1, 4'h0);
      req = 4'b0001;
      phase(1, 0, 8, 4'h0);
      req = 4'h0;
      phase(2, 0, 2, 4'h0);
      phase(0, 0, 1, 4'h0);
      phase(1, 1, 8, 4'h0);
      phase(2, 1, 2, 4'h0);
      phase(0, 1, 1, 4'h0);
      req = 4'b0011;
      cyc(1, 2, 4'h0, 0);
      req = 4'h0;
      for (int c = 1; c < MIN_G; c++) cyc(1, 2, 4'b0011, c);
      phase(2, 2, 2, 4'b0011);
      phase(0, 2, 1, 4'b0011);
      for (int c = 0; c < MIN_G; c++) cyc(1, 0, 4'b0010, c);
      phase(2, 0, 2, 4'b0010);
      phase(0, 0, 1, 4'b0010);
      phase(1, 1, 8, 4'h0);
      phase(2, 1, 2, 4'h0);
      phase(0, 1, 1, 4'h0);
      req = 4'b1000;
      cyc(1, 2, 4'h0, 0);
      req = 4'h0;
      cyc(1, 2, 4'b1000, 1);
      nrst = 1'b0;
      #1;
      check("rst_red", red, 4'hf);
      check("rst_yellow", yellow, 0);
      check("rst_green", green, 0);
      check("rst_pending", pending, 0);
      check("rst_active_dir", active_dir, 0);
      check("rst_walk", walk_v, 0);
      nrst = 1'b1;
      cyc(0, 0, 4'h0, 0);
      for (int c = 0; c < 8; c++) cyc(1, 0, 4'h0, c);
      cyc(2, 0, 4'h0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
